// File: rtl/local_inject_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : local_inject_arbiter
// Purpose  : Round-robin arbiter sharing one router Local input among sources.
// Revision : 1.0
// ============================================================================
module local_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int packetwidth = 26,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             ReqIn,
    input  logic [NUM_REQ*packetwidth-1:0] PacketIn,
    output logic [NUM_REQ-1:0]             GntIn,
    output logic [packetwidth-1:0]         PacketOut,
    output logic                           ReqDnStr,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [2:0]                     WinnerID,
    output logic                           Busy,
    output logic                           StallErr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [packetwidth-1:0]   pkt_q, pkt_d;
    logic [2:0]               win_q, win_d;
    logic [2:0]               last_q, last_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic                     req_q, req_d;
    logic                     busy_q, busy_d;
    logic                     stall_q, stall_d;
    logic [15:0]              cnt_q, cnt_d;

    logic                     w_any;
    logic [2:0]               w_pick;
    logic [packetwidth-1:0]   w_pkt;
    int                       w_dist;
    int                       w_best;

    // Winner = requester with the smallest rotational distance past last_q.
    always_comb begin
        w_any  = |ReqIn;
        w_pick = '0;
        w_pkt  = '0;
        w_dist = 0;
        w_best = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
            if (ReqIn[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = 3'(j);
                w_pkt  = PacketIn[j*packetwidth +: packetwidth];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        win_d   = win_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        busy_d  = busy_q;
        stall_d = stall_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!DnStrFull && w_any) begin
                    pkt_d   = w_pkt;
                    win_d   = w_pick;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (cnt_d >= 16'(TIMEOUT)) begin
                    stall_d = 1'b1;
                end
                if (GntDnStr) begin
                    req_d  = 1'b0;
                    last_d = win_q;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        gnt_d[j] = (3'(j) == win_q);
                    end
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            win_q   <= '0;
            last_q  <= 3'(NUM_REQ - 1);
            gnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GntIn     = gnt_q;
    assign PacketOut = pkt_q;
    assign ReqDnStr  = req_q;
    assign WinnerID  = win_q;
    assign Busy      = busy_q;
    assign StallErr  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_local_inject_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_local_inject_arbiter
// Purpose  : Directed vector bench for local_inject_arbiter.
// Revision : 1.0
// ============================================================================
module tb_local_inject_arbiter;

    localparam logic [25:0] PK0 = 26'h1234567;
    localparam logic [25:0] PK1 = 26'h2345678;
    localparam logic [25:0] PK2 = 26'h0ABCDEF;
    localparam logic [25:0] PK3 = 26'h3456789;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ReqIn;
    logic [103:0] PacketIn;
    logic [3:0]   GntIn;
    logic [25:0]  PacketOut;
    logic         ReqDnStr;
    logic         GntDnStr;
    logic         DnStrFull;
    logic [2:0]   WinnerID;
    logic         Busy;
    logic         StallErr;

    logic [25:0]  pk [4];

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string      nm;
        logic       rst;
        logic [3:0] req;
        logic       g;
        logic       f;
        logic       e_req;
        logic [3:0] e_gnt;
        logic [2:0] e_win;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    local_inject_arbiter #(
        .NUM_REQ    (4),
        .packetwidth(26),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ReqIn    (ReqIn),
        .PacketIn (PacketIn),
        .GntIn    (GntIn),
        .PacketOut(PacketOut),
        .ReqDnStr (ReqDnStr),
        .GntDnStr (GntDnStr),
        .DnStrFull(DnStrFull),
        .WinnerID (WinnerID),
        .Busy     (Busy),
        .StallErr (StallErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input logic rst, input logic [3:0] req,
                       input logic g, input logic f, input logic e_req,
                       input logic [3:0] e_gnt, input logic [2:0] e_win, input logic e_busy);
        vec_t v;
        v.nm = nm; v.rst = rst; v.req = req; v.g = g; v.f = f;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_win = e_win; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    initial begin
        int seq [6];
        pk[0] = PK0; pk[1] = PK1; pk[2] = PK2; pk[3] = PK3;
        PacketIn  = {PK3, PK2, PK1, PK0};
        reset     = 1'b1;
        ReqIn     = '0;
        GntDnStr  = 1'b0;
        DnStrFull = 1'b0;

        // Single source 2, router grants two cycles after the request.
        add("single_req",  0, 4'b0100, 0, 0, 1, 4'b0000, 3'd2, 1);
        add("single_wait", 0, 4'b0100, 0, 0, 1, 4'b0000, 3'd2, 1);
        add("single_gnt",  0, 4'b0100, 1, 0, 0, 4'b0100, 3'd2, 1);
        add("single_rel",  0, 4'b0100, 0, 0, 0, 4'b0000, 3'd2, 0);
        add("single_idle", 0, 4'b0000, 0, 0, 0, 4'b0000, 3'd2, 0);
        // Fresh pointer, then all sources requesting with a one-cycle sink.
        add("fair_reset",  1, 4'b1111, 0, 0, 0, 4'b0000, 3'd0, 0);
        seq = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            add("fair_send", 0, 4'b1111, 0, 0, 1, 4'b0000, 3'(seq[i]), 1);
            add("fair_gnt",  0, 4'b1111, 1, 0, 0, 4'b0001 << seq[i], 3'(seq[i]), 1);
            add("fair_rel",  0, 4'b1111, 0, 0, 0, 4'b0000, 3'(seq[i]), 0);
        end
        // Backpressure: ten cycles full, then the request goes out.
        for (int i = 0; i < 10; i++) begin
            add("bp_full", 0, 4'b0010, 0, 1, 0, 4'b0000, 3'd0, 0);
        end
        add("bp_send", 0, 4'b0010, 0, 0, 1, 4'b0000, 3'd1, 1);
        add("bp_gnt",  0, 4'b0010, 1, 0, 0, 4'b0010, 3'd1, 1);
        add("bp_rel",  0, 4'b0010, 0, 0, 0, 4'b0000, 3'd1, 0);
        add("bp_idle", 0, 4'b0000, 0, 0, 0, 4'b0000, 3'd1, 0);

        step();
        step();
        chk("rst_gnt",   32'(GntIn), 32'h0);
        chk("rst_req",   32'(ReqDnStr), 32'h0);
        chk("rst_pkt",   32'(PacketOut), 32'h0);
        chk("rst_win",   32'(WinnerID), 32'h0);
        chk("rst_busy",  32'(Busy), 32'h0);
        chk("rst_stall", 32'(StallErr), 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            ReqIn     = tbl[i].req;
            GntDnStr  = tbl[i].g;
            DnStrFull = tbl[i].f;
            step();
            chk({tbl[i].nm, "_req"},  32'(ReqDnStr), 32'(tbl[i].e_req));
            chk({tbl[i].nm, "_gnt"},  32'(GntIn),    32'(tbl[i].e_gnt));
            chk({tbl[i].nm, "_busy"}, 32'(Busy),     32'(tbl[i].e_busy));
            chk({tbl[i].nm, "_stall"}, 32'(StallErr), 32'h0);
            if (tbl[i].e_busy) begin
                chk({tbl[i].nm, "_win"}, 32'(WinnerID), 32'(tbl[i].e_win));
            end
            if (tbl[i].e_req) begin
                chk({tbl[i].nm, "_pkt"}, 32'(PacketOut), 32'(pk[tbl[i].e_win]));
                chk({tbl[i].nm, "_sender"}, 32'(PacketOut[14:9]), 32'(pk[tbl[i].e_win][14:9]));
            end
        end
        reset = 1'b0;

        // Stall: source 0 (pointer at 1) never granted until well past TIMEOUT.
        ReqIn = 4'b0001; GntDnStr = 1'b0; DnStrFull = 1'b0;
        step();
        chk("stall_req0", 32'(ReqDnStr), 32'h1);
        chk("stall_win", 32'(WinnerID), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("stall_hold", 32'(ReqDnStr), 32'h1);
            if (k == 15) chk("stall_pre", 32'(StallErr), 32'h0);
            if (k == 16) chk("stall_set", 32'(StallErr), 32'h1);
        end
        GntDnStr = 1'b1;
        step();
        chk("stall_gnt", 32'(GntIn), 32'h1);
        GntDnStr = 1'b0;
        step();
        chk("stall_rel_gnt", 32'(GntIn), 32'h0);
        chk("stall_rel_busy", 32'(Busy), 32'h0);
        ReqIn = 4'b0000;
        step();
        chk("stall_sticky", 32'(StallErr), 32'h1);

        // Reset while source 3 is in flight, even with a grant pending.
        ReqIn = 4'b1000;
        step();
        chk("rmid_req", 32'(ReqDnStr), 32'h1);
        chk("rmid_win", 32'(WinnerID), 32'h3);
        reset = 1'b1; GntDnStr = 1'b1;
        step();
        chk("rmid_req0", 32'(ReqDnStr), 32'h0);
        chk("rmid_gnt0", 32'(GntIn), 32'h0);
        chk("rmid_stall0", 32'(StallErr), 32'h0);
        reset = 1'b0; GntDnStr = 1'b0; ReqIn = 4'b1001;
        step();
        chk("rmid_gnt_none", 32'(GntIn), 32'h0);
        chk("rmid_first_win", 32'(WinnerID), 32'h0);
        chk("rmid_first_pkt", 32'(PacketOut), 32'(PK0));
        GntDnStr = 1'b1;
        step();
        chk("rmid_gnt_src0", 32'(GntIn), 32'h1);
        GntDnStr = 1'b0; ReqIn = 4'b1000;
        step();

        // Pointer wrap: source 3 again after last=3, with a spurious grant in IDLE.
        step();
        chk("wrap_win3", 32'(WinnerID), 32'h3);
        GntDnStr = 1'b1;
        step();
        chk("wrap_gnt3", 32'(GntIn), 32'h8);
        GntDnStr = 1'b0;
        step();
        ReqIn = 4'b0000; GntDnStr = 1'b1;
        step();
        chk("spur_gnt", 32'(GntIn), 32'h0);
        chk("spur_req", 32'(ReqDnStr), 32'h0);
        chk("spur_busy", 32'(Busy), 32'h0);
        GntDnStr = 1'b0; ReqIn = 4'b1000;
        step();
        chk("wrap_again_win", 32'(WinnerID), 32'h3);
        chk("wrap_again_req", 32'(ReqDnStr), 32'h1);
        chk("wrap_again_pkt", 32'(PacketOut), 32'(PK3));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
